// File: rtl/i2c_codec_ctrl_pkg.sv
// Shared types and constants for the codec I2C write master.
package i2c_codec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_DONE
  } state_e;

  typedef logic [1:0] quarter_t;

  localparam int NUM_BYTES     = 3;
  localparam int BITS_PER_BYTE = 8;
  localparam int BIT_CNT_W     = $clog2(BITS_PER_BYTE);
  localparam int BYTE_CNT_W    = $clog2(NUM_BYTES);

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(BITS_PER_BYTE - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(NUM_BYTES - 1);

endpackage

// File: rtl/i2c_codec_ctrl_if.sv
// Host/bus-side signal bundle of the codec I2C write master.
interface i2c_codec_ctrl_if;

  logic        start;
  logic [23:0] data_in;
  logic        busy;
  logic        done;
  logic        ack_err;
  logic        i2c_scl_o;
  logic        i2c_sda_oe;
  logic        i2c_sda_i;

  modport master (
    output start, data_in, i2c_sda_i,
    input  busy, done, ack_err, i2c_scl_o, i2c_sda_oe
  );

  modport slave (
    input  start, data_in, i2c_sda_i,
    output busy, done, ack_err, i2c_scl_o, i2c_sda_oe
  );

endinterface

// File: rtl/i2c_codec_ctrl_quarter_tick.sv
// Quarter-bit divider: one-cycle tick every CLK_DIV clocks, held at zero while cleared.
module i2c_quarter_tick
  import i2c_codec_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap && !i_clear;

  always_ff @(posedge clk) begin
    if (i_clear || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_codec_ctrl.sv
// Three-byte I2C write master for the audio codec configuration word.
// Optional slave ACK checking with early STOP: define I2C_CODEC_ACK_CHECK_EN.
module i2c_codec_ctrl
  import i2c_codec_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic             clk,
  input  logic             reset,
  i2c_codec_ctrl_if.slave  bus
);

  state_e                r_state;
  quarter_t              r_quarter;
  logic [23:0]           r_shift;
  logic [BIT_CNT_W-1:0]  r_bitCnt;
  logic [BYTE_CNT_W-1:0] r_byteCnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ackErr;
  logic                  r_scl;
  logic                  r_sdaOe;

  logic w_tick;
  logic w_divClear;
  logic w_lastByte;
  logic w_abort;

  assign w_divClear = reset || (r_state == ST_IDLE);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_quarterTick (
    .clk     (clk),
    .i_clear (w_divClear),
    .o_tick  (w_tick)
  );

  assign w_lastByte = (r_byteCnt == LAST_BYTE);

`ifdef I2C_CODEC_ACK_CHECK_EN
  assign w_abort = r_ackErr;
`else
  logic w_unusedSda;
  assign w_unusedSda = bus.i2c_sda_i;
  assign w_abort     = 1'b0;
`endif

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.ack_err    = r_ackErr;
  assign bus.i2c_scl_o  = r_scl;
  assign bus.i2c_sda_oe = r_sdaOe;

  // Line levels are registered for the quarter being entered, so each tick sets up the next quarter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_quarter <= '0;
      r_shift   <= '0;
      r_bitCnt  <= '0;
      r_byteCnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ackErr  <= 1'b0;
      r_scl     <= 1'b1;
      r_sdaOe   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.data_in;
            r_ackErr  <= 1'b0;
            r_busy    <= 1'b1;
            r_quarter <= '0;
            r_state   <= ST_START;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          if (w_tick) begin
            if (r_quarter != 2'd3) begin
              r_quarter <= r_quarter + 2'd1;
              case (r_state)
                ST_START: if (r_quarter == 2'd1) r_sdaOe <= 1'b1;
                ST_STOP: begin
                  if (r_quarter == 2'd0) r_scl   <= 1'b1;
                  if (r_quarter == 2'd1) r_sdaOe <= 1'b0;
                end
                default: if (r_quarter == 2'd1) r_scl <= 1'b1;
              endcase
`ifdef I2C_CODEC_ACK_CHECK_EN
              // Last clock of q2 is the ACK sample point.
              if (r_state == ST_ACK && r_quarter == 2'd2 && bus.i2c_sda_i) begin
                r_ackErr <= 1'b1;
              end
`endif
            end else begin
              r_quarter <= '0;
              case (r_state)
                ST_START: begin
                  r_state   <= ST_BIT;
                  r_bitCnt  <= '0;
                  r_byteCnt <= '0;
                  r_scl     <= 1'b0;
                  r_sdaOe   <= ~r_shift[23];
                end
                ST_BIT: begin
                  r_shift <= {r_shift[22:0], 1'b0};
                  r_scl   <= 1'b0;
                  if (r_bitCnt == LAST_BIT) begin
                    r_state <= ST_ACK;
                    r_sdaOe <= 1'b0;
                  end else begin
                    r_bitCnt <= r_bitCnt + 1'b1;
                    r_sdaOe  <= ~r_shift[22];
                  end
                end
                ST_ACK: begin
                  r_scl <= 1'b0;
                  if (w_abort || w_lastByte) begin
                    r_state <= ST_STOP;
                    r_sdaOe <= 1'b1;
                  end else begin
                    r_state   <= ST_BIT;
                    r_bitCnt  <= '0;
                    r_byteCnt <= r_byteCnt + 1'b1;
                    r_sdaOe   <= ~r_shift[23];
                  end
                end
                ST_STOP: begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_codec_ctrl.sv
// Scoreboard bench for i2c_codec_ctrl: bytes decoded off the bus are checked against a queue
// filled when each word is issued; honours I2C_CODEC_ACK_CHECK_EN when it is defined.
module tb_i2c_codec_ctrl;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset;
  logic slavePull;

  always #5 clk = ~clk;

  i2c_codec_ctrl_if bus ();
  i2c_codec_ctrl_if fastBus ();

  assign bus.i2c_sda_i     = ~(bus.i2c_sda_oe | slavePull);
  assign fastBus.i2c_sda_i = 1'b0;

  i2c_codec_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  i2c_codec_ctrl #(.CLK_DIV(1)) dutFast (
    .clk   (clk),
    .reset (reset),
    .bus   (fastBus)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] expQ[$];
  int         nackIdx    = -1;
  bit         monitorOn  = 1'b1;
  int         bitCount   = 0;
  int         byteNum    = 0;
  int         startCount = 0;
  int         stopCount  = 0;
  bit         ackPhase   = 1'b0;
  logic [7:0] shiftIn    = '0;
  logic       prevScl    = 1'b1;
  logic       prevSda    = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Bus-side slave: decodes START/STOP and bytes, drives ACK (or NACK on byte nackIdx).
  always @(negedge clk) begin
    logic sdaNow;
    logic [7:0] expByte;
    sdaNow = ~(bus.i2c_sda_oe | slavePull);
    if (monitorOn) begin
      if (prevScl && bus.i2c_scl_o && prevSda && !sdaNow) begin
        startCount++;
        bitCount = 0;
        byteNum  = 0;
        ackPhase = 1'b0;
      end else if (prevScl && bus.i2c_scl_o && !prevSda && sdaNow) begin
        stopCount++;
      end else if (!prevScl && bus.i2c_scl_o) begin
        if (bitCount < 8) begin
          shiftIn = {shiftIn[6:0], sdaNow};
          bitCount++;
          if (bitCount == 8) begin
            checkOutput("byteExpected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
              expByte = expQ.pop_front();
              checkOutput("busByte", 32'(shiftIn), 32'(expByte));
            end
          end
        end else begin
          bitCount = 0;
        end
      end else if (prevScl && !bus.i2c_scl_o) begin
        if (bitCount == 8 && !ackPhase) begin
          ackPhase  = 1'b1;
          slavePull = (byteNum != nackIdx);
        end else if (ackPhase && bitCount == 0) begin
          ackPhase  = 1'b0;
          slavePull = 1'b0;
          byteNum++;
        end
      end
    end
    prevScl = bus.i2c_scl_o;
    prevSda = sdaNow;
  end

  task automatic applyStimulus(input logic [23:0] word, input int nackAt, input bit pokeMid);
    int   sentBytes;
    int   busyCycles;
    int   doneCycles;
    int   startBase;
    int   stopBase;
    int   expCycles;
    logic expAckErr;
    sentBytes = 3;
    expAckErr = 1'b0;
`ifdef I2C_CODEC_ACK_CHECK_EN
    if (nackAt >= 0 && nackAt < 3) begin
      sentBytes = nackAt + 1;
      expAckErr = 1'b1;
    end
`endif
    expCycles = 4 * CLK_DIV * (2 + 9 * sentBytes);
    for (int b = 0; b < sentBytes; b++) expQ.push_back(word[23 - 8*b -: 8]);
    nackIdx   = nackAt;
    startBase = startCount;
    stopBase  = stopCount;

    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = word;
    @(negedge clk);
    bus.start  = 1'b0;
    busyCycles = 0;
    while (bus.busy && !bus.done && busyCycles < 2000) begin
      busyCycles++;
      bus.start = pokeMid && (busyCycles == 100);
      if (pokeMid && busyCycles == 100) bus.data_in = 24'hFFFFFF;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checkOutput("busyCycles", 32'(busyCycles), 32'(expCycles));
    checkOutput("busyDuringDone", 32'(bus.busy), 32'd1);
    doneCycles = 0;
    while (bus.done && doneCycles < 5) begin
      doneCycles++;
      @(negedge clk);
    end
    checkOutput("donePulseLen", 32'(doneCycles), 32'd1);
    checkOutput("busyAfterDone", 32'(bus.busy), 32'd0);
    checkOutput("sclReleased", 32'(bus.i2c_scl_o), 32'd1);
    checkOutput("sdaReleased", 32'(bus.i2c_sda_oe), 32'd0);
    checkOutput("ackErr", 32'(bus.ack_err), 32'(expAckErr));
    checkOutput("startSeen", 32'(startCount - startBase), 32'd1);
    checkOutput("stopSeen", 32'(stopCount - stopBase), 32'd1);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    nackIdx = -1;
  endtask

  initial begin
    int fastCycles;
    reset           = 1'b1;
    slavePull       = 1'b0;
    bus.start       = 1'b0;
    bus.data_in     = '0;
    fastBus.start   = 1'b0;
    fastBus.data_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstDone", 32'(bus.done), 32'd0);
    checkOutput("rstAckErr", 32'(bus.ack_err), 32'd0);
    checkOutput("rstScl", 32'(bus.i2c_scl_o), 32'd1);
    checkOutput("rstSdaOe", 32'(bus.i2c_sda_oe), 32'd0);
    reset = 1'b0;

    $display("[TB] CLK_DIV=1 instance, SDA held low");
    @(negedge clk);
    fastBus.start   = 1'b1;
    fastBus.data_in = 24'h341E00;
    @(negedge clk);
    fastBus.start = 1'b0;
    fastCycles    = 0;
    while (fastBus.busy && !fastBus.done && fastCycles < 1000) begin
      fastCycles++;
      @(negedge clk);
    end
    checkOutput("fastBusyCycles", 32'(fastCycles), 32'd116);
    checkOutput("fastDone", 32'(fastBus.done), 32'd1);
    checkOutput("fastAckErr", 32'(fastBus.ack_err), 32'd0);
    repeat (2) @(negedge clk);

    $display("[TB] plain write 0x341E00");
    applyStimulus(24'h341E00, -1, 1'b0);
    $display("[TB] write with start poked mid-transfer");
    applyStimulus(24'h341E00, -1, 1'b1);
    $display("[TB] slave NACKs second byte");
    applyStimulus(24'h341E00, 1, 1'b0);

    $display("[TB] reset during second byte");
    monitorOn = 1'b0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 24'h5A5A5A;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (220) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstScl", 32'(bus.i2c_scl_o), 32'd1);
    checkOutput("midRstSdaOe", 32'(bus.i2c_sda_oe), 32'd0);
    checkOutput("midRstDone", 32'(bus.done), 32'd0);
    reset     = 1'b0;
    slavePull = 1'b0;
    @(negedge clk);
    monitorOn = 1'b1;
    applyStimulus(24'hA5C35A, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
